uart_rx_simple: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 15 +
 rtl/uart_rx_simple.sv | 135 +++++++++++++
 tb/tb_uart_rx_simple.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, RX state encoding and baud divisor helper
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchroniser (reset to idle-high) plus falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic serial_rx,
  output logic line,
  output logic fall
);
  logic [2:0] sr_q, sr_d;
  assign sr_d = {sr_q[1:0], serial_rx};
  assign line = sr_q[1];
  assign fall = sr_q[2] & ~sr_q[1];
  // shift the pin through two sync stages and one edge-detect stage
  always_ff @(posedge clk) sr_q <= rst ? 3'b111 : sr_d;
endmodule

// File: rtl/uart_rx_simple.sv
// uart_rx_simple: 8-bit UART receiver, optional parity, 1/2 stop bits; UART_RX_MAJORITY_EN enables 2-of-3 sample voting
module uart_rx_simple
  import uart_pkg::*;
#(
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_FREQ_HZ = 33330000,
  parameter int PARITY      = 0,
  parameter int STOP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);
  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HB  = CPB / 2;
  localparam int CW  = $clog2(CPB) + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  // with voting, the decision lands one cycle after the nominal point; restarting
  // the counter at OFF keeps successive sample points exactly CPB apart
  localparam logic [CW-1:0] START_PT = CW'(HB - 1 + OFF);
  localparam logic [CW-1:0] BIT_PT   = CW'(CPB - 1 + OFF);
  localparam logic [CW-1:0] CNT_RST  = CW'(OFF);
  logic line, fall, s, tick;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, rx_byte_q, rx_byte_d;
  logic perr_q, perr_d, ferr_q, ferr_d, valid_q, valid_d, pe_q, pe_d, fe_q, fe_d;
  uart_rx_sync u_sync (.clk(clk), .rst(rst), .serial_rx(serial_rx), .line(line), .fall(fall));
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  assign s = (line & hist_q[0]) | (line & hist_q[1]) | (hist_q[0] & hist_q[1]);
  // two-deep history of the synchronised line for the vote
  always_ff @(posedge clk) hist_q <= rst ? 2'b11 : {hist_q[0], line};
`else
  assign s = line;
`endif
  assign tick = cnt_q == ((state_q == ST_START) ? START_PT : BIT_PT);
  assign rx_byte = rx_byte_q;
  assign byte_valid = valid_q;
  assign parity_error = pe_q;
  assign frame_error = fe_q;
  assign busy = state_q != ST_IDLE;
  // frame sequencing: start validation, data shift, parity, stop and result capture
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    rx_byte_d = rx_byte_q;
    valid_d = 1'b0;
    pe_d = 1'b0;
    fe_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = ST_START;
          idx_d = '0;
          perr_d = 1'b0;
          ferr_d = 1'b0;
        end
      end
      ST_START: if (tick) begin
        cnt_d = CNT_RST;
        state_d = s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (tick) begin
        cnt_d = CNT_RST;
        shift_d = {s, shift_q[7:1]};
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd7) begin
          idx_d = '0;
          state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
        end
      end
      ST_PAR: if (tick) begin
        cnt_d = CNT_RST;
        perr_d = (^{shift_q, s}) ^ (PARITY == PARITY_ODD);
        state_d = ST_STOP;
      end
      ST_STOP: if (tick) begin
        cnt_d = CNT_RST;
        ferr_d = ferr_q | ~s;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(STOP - 1)) begin
          state_d = ST_DONE;
          rx_byte_d = shift_q;
          valid_d = 1'b1;
          pe_d = perr_q;
          fe_d = ferr_q | ~s;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      rx_byte_q <= '0;
      valid_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      rx_byte_q <= rx_byte_d;
      valid_q <= valid_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_simple.sv
// tb_uart_rx_simple: randomized/directed frame stimulus checked against a bit-level serial model
module tb_uart_rx_simple;
  localparam int CPB = 33330000 / 115200;
`ifdef UART_RX_MAJORITY_EN
  localparam int GOFF = CPB / 2;
`else
  localparam int GOFF = CPB / 4;
`endif
  typedef struct {
    logic [7:0] b;
    logic pe;
    logic fe;
    int t;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rxp = 1'b1;
  logic [7:0] rb0, rbp;
  logic v0, vp, pe0, pep, fe0, fep, busy0, busyp;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int bad = 0;
  ev_t q0[$];
  ev_t qp[$];

  uart_rx_simple dut0 (.clk(clk), .rst(rst), .serial_rx(rx0), .rx_byte(rb0), .byte_valid(v0),
                       .parity_error(pe0), .frame_error(fe0), .busy(busy0));
  uart_rx_simple #(.PARITY(2), .STOP(2)) dutp (.clk(clk), .rst(rst), .serial_rx(rxp), .rx_byte(rbp),
                       .byte_valid(vp), .parity_error(pep), .frame_error(fep), .busy(busyp));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (v0) begin
      e.b = rb0; e.pe = pe0; e.fe = fe0; e.t = cyc;
      q0.push_back(e);
    end
    if (vp) begin
      e.b = rbp; e.pe = pep; e.fe = fep; e.t = cyc;
      qp.push_back(e);
    end
    if ((!v0 && (pe0 || fe0)) || (!vp && (pep || fep))) bad++;
  end

  task automatic hold(input int which, input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      if (which == 0) rx0 = v; else rxp = v;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // serialise one frame: start, 8 data LSB-first, optional parity, stop bits
  task automatic send(input int which, input logic [7:0] b, input int par, input logic flip,
                      input int nstop, input logic stop_val, input int goff, input int abort_bit);
    logic bits[$];
    logic v;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par != 0) bits.push_back((^b) ^ (par == 1) ^ flip);
    for (int i = 0; i < nstop; i++) bits.push_back(stop_val);
    for (int k = 0; k < bits.size(); k++)
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (k == abort_bit && c == CPB / 2) begin
          rst = 1'b1;
          if (which == 0) rx0 = 1'b1; else rxp = 1'b1;
          return;
        end
        v = bits[k];
        if (goff >= 0 && k >= 1 && k <= 8 && c == goff) v = ~v;
        if (which == 0) rx0 = v; else rxp = v;
      end
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    n_checks += 5;
    if (rb0 !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte got %h want 00", rb0); end
    if (v0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", v0); end
    if (pe0 !== 1'b0 || pep !== 1'b0) begin n_fail++; $display("FAIL reset_pe got %b%b want 00", pe0, pep); end
    if (fe0 !== 1'b0 || fep !== 1'b0) begin n_fail++; $display("FAIL reset_fe got %b%b want 00", fe0, fep); end
    if (busy0 !== 1'b0 || busyp !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b%b want 00", busy0, busyp); end
    rst = 1'b0;
    hold(0, 1'b1, 20);
  endtask

  task automatic test_loopback;
    for (int i = 0; i < 3; i++) send(0, 8'h88, 0, 1'b0, 1, 1'b1, -1, -1);
    settle(5);
    n_checks++;
    if (q0.size() != 3) begin n_fail++; $display("FAIL loop_count got %0d want 3", q0.size()); end
    for (int i = 0; i < q0.size(); i++) begin
      n_checks += 2;
      if (q0[i].b !== 8'h88) begin n_fail++; $display("FAIL loop_byte[%0d] got %h want 88", i, q0[i].b); end
      if (q0[i].pe !== 1'b0 || q0[i].fe !== 1'b0) begin n_fail++; $display("FAIL loop_err[%0d] got pe=%b fe=%b want 0", i, q0[i].pe, q0[i].fe); end
      if (i > 0) begin
        n_checks++;
        if ((q0[i].t - q0[i-1].t) < 10 * CPB - 1 || (q0[i].t - q0[i-1].t) > 10 * CPB + 1) begin
          n_fail++; $display("FAIL loop_spacing[%0d] got %0d want %0d+-1", i, q0[i].t - q0[i-1].t, 10 * CPB);
        end
      end
    end
    q0.delete();
  endtask

  task automatic test_parity;
    send(1, 8'h88, 2, 1'b0, 2, 1'b1, -1, -1);
    send(1, 8'h88, 2, 1'b1, 2, 1'b1, -1, -1);
    settle(5);
    n_checks++;
    if (qp.size() != 2) begin n_fail++; $display("FAIL par_count got %0d want 2", qp.size()); end
    else begin
      n_checks += 4;
      if (qp[0].pe !== 1'b0) begin n_fail++; $display("FAIL par_good_pe got %b want 0", qp[0].pe); end
      if (qp[1].pe !== 1'b1) begin n_fail++; $display("FAIL par_bad_pe got %b want 1", qp[1].pe); end
      if (qp[1].b !== 8'h88) begin n_fail++; $display("FAIL par_bad_byte got %h want 88", qp[1].b); end
      if (qp[0].fe !== 1'b0 || qp[1].fe !== 1'b0) begin n_fail++; $display("FAIL par_fe got %b%b want 00", qp[0].fe, qp[1].fe); end
    end
    qp.delete();
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send(1, b, 2, 1'b0, 2, 1'b1, -1, -1);
    end
    settle(5);
    n_checks++;
    if (qp.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", qp.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (qp[i].b !== exp_q[i] || qp[i].pe !== 1'b0 || qp[i].fe !== 1'b0) begin
        n_fail++; $display("FAIL rand[%0d] got %h pe=%b fe=%b want %h pe=0 fe=0", i, qp[i].b, qp[i].pe, qp[i].fe, exp_q[i]);
      end
    end
    qp.delete();
  endtask

  task automatic test_glitch;
    int waited;
    hold(0, 1'b0, 100);
    hold(0, 1'b1, 1);
    waited = 0;
    while (busy0 !== 1'b0 && waited < 150) begin @(negedge clk); waited++; end
    n_checks++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0 within 150", busy0); end
    hold(0, 1'b1, 2 * CPB);
    n_checks++;
    if (q0.size() != 0) begin n_fail++; $display("FAIL glitch_novalid got %0d want 0", q0.size()); end
    send(0, 8'h5A, 0, 1'b0, 1, 1'b1, -1, -1);
    settle(5);
    n_checks++;
    if (q0.size() != 1 || q0[0].b !== 8'h5A) begin n_fail++; $display("FAIL glitch_next got n=%0d want 5a once", q0.size()); end
    q0.delete();
  endtask

  task automatic test_frame_error;
    send(0, 8'hFF, 0, 1'b0, 1, 1'b0, -1, -1);
    hold(0, 1'b0, 5 * CPB);
    settle(1);
    n_checks++;
    if (q0.size() != 1) begin n_fail++; $display("FAIL fe_count got %0d want 1", q0.size()); end
    else begin
      n_checks += 2;
      if (q0[0].fe !== 1'b1 || q0[0].pe !== 1'b0) begin n_fail++; $display("FAIL fe_flags got fe=%b pe=%b want fe=1 pe=0", q0[0].fe, q0[0].pe); end
      if (q0[0].b !== 8'hFF) begin n_fail++; $display("FAIL fe_byte got %h want ff", q0[0].b); end
    end
    hold(0, 1'b1, CPB);
    n_checks++;
    if (q0.size() != 1) begin n_fail++; $display("FAIL fe_quiet got %0d want 1", q0.size()); end
    send(0, 8'h0F, 0, 1'b0, 1, 1'b1, -1, -1);
    settle(5);
    n_checks++;
    if (q0.size() != 2 || q0[q0.size()-1].b !== 8'h0F || q0[q0.size()-1].fe !== 1'b0) begin
      n_fail++; $display("FAIL fe_recover got n=%0d want 2 with last 0f fe=0", q0.size());
    end
    q0.delete();
  endtask

  task automatic test_reset_mid;
    send(0, 8'h3C, 0, 1'b0, 1, 1'b1, -1, 4);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({rb0, v0, pe0, fe0, busy0} !== 12'h000) begin
      n_fail++; $display("FAIL rstmid_outputs got byte=%h v=%b pe=%b fe=%b busy=%b want all 0", rb0, v0, pe0, fe0, busy0);
    end
    hold(0, 1'b1, 12 * CPB);
    n_checks++;
    if (q0.size() != 0) begin n_fail++; $display("FAIL rstmid_novalid got %0d want 0", q0.size()); end
    send(0, 8'h55, 0, 1'b0, 1, 1'b1, -1, -1);
    settle(5);
    n_checks++;
    if (q0.size() != 1 || rb0 !== 8'h55) begin n_fail++; $display("FAIL rstmid_next got n=%0d byte=%h want 1 55", q0.size(), rb0); end
    q0.delete();
  endtask

  task automatic test_back_to_back;
    send(0, 8'hA5, 0, 1'b0, 1, 1'b1, GOFF, -1);
    send(0, 8'hC3, 0, 1'b0, 1, 1'b1, GOFF, -1);
    settle(5);
    n_checks++;
    if (q0.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", q0.size()); end
    else begin
      n_checks += 2;
      if (q0[0].b !== 8'hA5) begin n_fail++; $display("FAIL b2b_first got %h want a5", q0[0].b); end
      if (q0[1].b !== 8'hC3) begin n_fail++; $display("FAIL b2b_second got %h want c3", q0[1].b); end
    end
    q0.delete();
  endtask

  task automatic test_flags_qualified;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL flags_unqualified got %0d cycles want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_parity;
    test_random;
    test_glitch;
    test_frame_error;
    test_reset_mid;
    test_back_to_back;
    test_flags_qualified;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
